// File: rtl/aor_key_pkg.sv
// Shared constants and state type for the AOR key loader.
// Defaults size a 64-bit key that is loaded one byte at a time.
package aor_key_pkg;

  localparam int KEY_W  = 64;
  localparam int BYTE_W = 8;
  localparam int NBYTES = KEY_W / BYTE_W;
  localparam int CNT_W  = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_READY,
    S_ERROR
  } state_e;

endpackage

// File: rtl/aor_key_loader_if.sv
// Byte-stream handshake between a key source (master) and the key loader (slave).
// Signal suffixes are named from the loader's point of view.
interface aor_key_loader_if #(
  parameter int BYTE_W = aor_key_pkg::BYTE_W
);

  logic              key_start_i;
  logic [BYTE_W-1:0] key_byte_i;
  logic              key_byte_valid_i;
  logic              key_byte_ready_o;

  modport master (
    output key_start_i,
    output key_byte_i,
    output key_byte_valid_i,
    input  key_byte_ready_o
  );

  modport slave (
    input  key_start_i,
    input  key_byte_i,
    input  key_byte_valid_i,
    output key_byte_ready_o
  );

endinterface

// File: rtl/aor_key_chk.sv
// Running XOR over every accepted byte, including the trailing checksum byte.
// A correct checksum therefore leaves the accumulator at zero.
module aor_key_chk #(
  parameter int BYTE_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              acc_i,
  input  logic [BYTE_W-1:0] byte_i,
  output logic              match_o
);

  logic [BYTE_W-1:0] sum_q;
  logic [BYTE_W-1:0] sum_d;

  // Clear and accumulate together restart the sum at the incoming byte.
  always_comb begin
    sum_d = sum_q;
    if (clr_i) begin
      sum_d = '0;
    end
    if (acc_i) begin
      sum_d = sum_d ^ byte_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign match_o = (sum_q == '0);

endmodule

// File: rtl/aor_key_loader.sv
// Serial key loader for the locked adder: collects key bytes plus an XOR checksum
// into a shadow register and commits the key only after the checksum matches.
module aor_key_loader #(
  parameter int KEY_W  = aor_key_pkg::KEY_W,
  parameter int BYTE_W = aor_key_pkg::BYTE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  aor_key_loader_if.slave   bus,
  input  logic              key_lock_i,
  output logic [KEY_W-1:0]  keyinput_o,
  output logic              key_valid_o,
  output logic              key_err_o,
  output logic              key_locked_o
);

  import aor_key_pkg::CNT_W;
  import aor_key_pkg::state_e;
  import aor_key_pkg::S_IDLE;
  import aor_key_pkg::S_LOAD;
  import aor_key_pkg::S_CHECK;
  import aor_key_pkg::S_READY;
  import aor_key_pkg::S_ERROR;

  localparam int NBYTES = KEY_W / BYTE_W;

  state_e             state_q,  state_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic [KEY_W-1:0]   shadow_q, shadow_d;
  logic [KEY_W-1:0]   key_q,    key_d;
  logic               valid_q,  valid_d;
  logic               err_q,    err_d;
  logic               locked_q, locked_d;

  logic               chk_clr;
  logic               chk_acc;
  logic               chk_match;

  aor_key_chk #(
    .BYTE_W (BYTE_W)
  ) u_chk (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (chk_clr),
    .acc_i   (chk_acc),
    .byte_i  (bus.key_byte_i),
    .match_o (chk_match)
  );

  // Ready is a pure state decode so no input ever reaches an output combinationally.
  assign bus.key_byte_ready_o = (state_q == S_LOAD);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    key_d    = key_q;
    valid_d  = valid_q;
    err_d    = err_q;
    locked_d = locked_q;
    chk_clr  = 1'b0;
    chk_acc  = 1'b0;

    case (state_q)
      S_IDLE, S_ERROR: begin
        if (bus.key_start_i) begin
          state_d  = S_LOAD;
          cnt_d    = '0;
          shadow_d = '0;
          err_d    = 1'b0;
          chk_clr  = 1'b1;
        end
      end

      S_LOAD: begin
        if (bus.key_start_i) begin
          cnt_d   = '0;
          chk_clr = 1'b1;
        end
        if (bus.key_byte_valid_i) begin
          chk_acc = 1'b1;
          if (bus.key_start_i) begin
            // A byte arriving with a restart becomes byte 0 of the new load.
            shadow_d[BYTE_W-1:0] = bus.key_byte_i;
            cnt_d                = CNT_W'(1);
          end else if (cnt_q == CNT_W'(NBYTES)) begin
            cnt_d   = '0;
            state_d = S_CHECK;
          end else begin
            for (int k = 0; k < NBYTES; k++) begin
              if (cnt_q == CNT_W'(k)) begin
                shadow_d[k*BYTE_W +: BYTE_W] = bus.key_byte_i;
              end
            end
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      S_CHECK: begin
        if (chk_match) begin
          key_d   = shadow_q;
          valid_d = 1'b1;
          err_d   = 1'b0;
          state_d = S_READY;
        end else begin
          err_d   = 1'b1;
          state_d = S_ERROR;
        end
      end

      S_READY: begin
        if (key_lock_i) begin
          locked_d = 1'b1;
        end
        // The old key stays on keyinput_o until the next successful commit.
        if (bus.key_start_i && !locked_q) begin
          state_d  = S_LOAD;
          valid_d  = 1'b0;
          cnt_d    = '0;
          shadow_d = '0;
          chk_clr  = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      key_q    <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      key_q    <= key_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      locked_q <= locked_d;
    end
  end

  assign keyinput_o   = key_q;
  assign key_valid_o  = valid_q;
  assign key_err_o    = err_q;
  assign key_locked_o = locked_q;

endmodule

// File: tb/tb_aor_key_loader.sv
// Self-checking bench for aor_key_loader: directed scenarios plus randomized traffic
// compared each cycle against a queue-based reference model.
module tb_aor_key_loader;

  localparam int NB = 8;
  localparam int M_IDLE  = 0;
  localparam int M_LOAD  = 1;
  localparam int M_CHECK = 2;
  localparam int M_READY = 3;
  localparam int M_ERROR = 4;

  logic        clk;
  logic        rst_n;
  logic        keyLock;
  logic [63:0] keyinput;
  logic        keyValid;
  logic        keyErr;
  logic        keyLocked;

  int compared;
  int mismatched;

  int          mMode;
  logic [7:0]  mBytes[$];
  logic [63:0] mKey;
  bit          mValid;
  bit          mErr;
  bit          mLocked;

  aor_key_loader_if #(.BYTE_W(8)) bus ();

  aor_key_loader #(
    .KEY_W  (64),
    .BYTE_W (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .key_lock_i   (keyLock),
    .keyinput_o   (keyinput),
    .key_valid_o  (keyValid),
    .key_err_o    (keyErr),
    .key_locked_o (keyLocked)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [7:0] keyXor();
    logic [7:0] x = 8'h00;
    for (int i = 0; i < NB; i++) x = x ^ mBytes[i];
    return x;
  endfunction

  function automatic logic [63:0] packKey();
    logic [63:0] k = 64'h0;
    for (int i = 0; i < NB; i++) k = k | (64'(mBytes[i]) << (8 * i));
    return k;
  endfunction

  task automatic modelReset();
    mMode = M_IDLE;
    mBytes.delete();
    mKey = 64'h0;
    mValid = 1'b0;
    mErr = 1'b0;
    mLocked = 1'b0;
  endtask

  task automatic modelStep(input bit st, input bit v, input logic [7:0] b, input bit lk);
    bit wasLocked;
    case (mMode)
      M_IDLE, M_ERROR: begin
        if (st) begin
          mMode = M_LOAD;
          mBytes.delete();
          mErr = 1'b0;
        end
      end
      M_LOAD: begin
        if (st) mBytes.delete();
        if (v) mBytes.push_back(b);
        if (mBytes.size() == NB + 1) mMode = M_CHECK;
      end
      M_CHECK: begin
        if (keyXor() == mBytes[NB]) begin
          mKey = packKey();
          mValid = 1'b1;
          mErr = 1'b0;
          mMode = M_READY;
        end else begin
          mErr = 1'b1;
          mMode = M_ERROR;
        end
      end
      M_READY: begin
        wasLocked = mLocked;
        if (lk) mLocked = 1'b1;
        if (st && !wasLocked) begin
          mMode = M_LOAD;
          mValid = 1'b0;
          mBytes.delete();
        end
      end
      default: ;
    endcase
  endtask

  task automatic checkModel();
    checkOutput("keyinput", keyinput, mKey);
    checkOutput("key_valid", 64'(keyValid), 64'(mValid));
    checkOutput("key_err", 64'(keyErr), 64'(mErr));
    checkOutput("key_locked", 64'(keyLocked), 64'(mLocked));
    checkOutput("byte_ready", 64'(bus.key_byte_ready_o), 64'(mMode == M_LOAD));
  endtask

  // One clock of stimulus: drive on the falling edge, sample 1ns after the rising edge.
  task automatic applyStimulus(input bit st, input bit v, input logic [7:0] b, input bit lk);
    @(negedge clk);
    bus.key_start_i      = st;
    bus.key_byte_valid_i = v;
    bus.key_byte_i       = b;
    keyLock              = lk;
    @(posedge clk);
    modelStep(st, v, b, lk);
    #1;
    checkModel();
  endtask

  task automatic doReset(input bit v, input logic [7:0] b);
    @(negedge clk);
    bus.key_start_i      = 1'b0;
    bus.key_byte_valid_i = v;
    bus.key_byte_i       = b;
    keyLock              = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("rst_keyinput", keyinput, 64'h0);
    checkOutput("rst_valid", 64'(keyValid), 64'h0);
    checkOutput("rst_err", 64'(keyErr), 64'h0);
    checkOutput("rst_locked", 64'(keyLocked), 64'h0);
    checkOutput("rst_ready", 64'(bus.key_byte_ready_o), 64'h0);
    bus.key_byte_valid_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic loadBytes(input logic [63:0] key, input logic [7:0] csum);
    for (int i = 0; i < NB; i++) applyStimulus(1'b0, 1'b1, key[8*i +: 8], 1'b0);
    applyStimulus(1'b0, 1'b1, csum, 1'b0);
  endtask

  initial begin
    logic [7:0] rb;
    bit rs, rv, rl;
    compared   = 0;
    mismatched = 0;
    rst_n      = 1'b0;
    keyLock    = 1'b0;
    bus.key_start_i      = 1'b0;
    bus.key_byte_valid_i = 1'b0;
    bus.key_byte_i       = 8'h00;
    modelReset();

    doReset(1'b0, 8'h00);

    // Bad checksum straight after reset: key stays zero, error flagged.
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    loadBytes(64'h1122334455667788, 8'h89);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("bad_err", 64'(keyErr), 64'h1);
    checkOutput("bad_valid", 64'(keyValid), 64'h0);
    checkOutput("bad_key", keyinput, 64'h0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    checkOutput("bad_start_clears_err", 64'(keyErr), 64'h0);

    // Good load; commit lands one edge after the checksum handshake.
    loadBytes(64'h1122334455667788, 8'h88);
    checkOutput("good_latency_valid", 64'(keyValid), 64'h0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("good_key", keyinput, 64'h1122334455667788);
    checkOutput("good_valid", 64'(keyValid), 64'h1);
    checkOutput("good_err", 64'(keyErr), 64'h0);

    // Unlocked reload with a restart mid-load; old key held until commit.
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    checkOutput("reload_valid_low", 64'(keyValid), 64'h0);
    checkOutput("reload_key_held", keyinput, 64'h1122334455667788);
    for (int i = 1; i <= 3; i++) applyStimulus(1'b0, 1'b1, 8'(i), 1'b0);
    applyStimulus(1'b1, 1'b1, 8'hAA, 1'b0);
    for (int i = 1; i <= 7; i++) applyStimulus(1'b0, 1'b1, 8'hB0 + 8'(i), 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h1A, 1'b0);
    checkOutput("restart_key_still_old", keyinput, 64'h1122334455667788);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("restart_byte0", 64'(keyinput[7:0]), 64'hAA);
    checkOutput("restart_key", keyinput, 64'hB7B6B5B4B3B2B1AA);

    // Lock, then a start and an all-ones reload must be ignored.
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    checkOutput("lock_set", 64'(keyLocked), 64'h1);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    checkOutput("lock_start_ignored", 64'(bus.key_byte_ready_o), 64'h0);
    loadBytes(64'hFFFFFFFFFFFFFFFF, 8'h00);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("lock_key_kept", keyinput, 64'hB7B6B5B4B3B2B1AA);
    checkOutput("lock_sticky", 64'(keyLocked), 64'h1);
    checkOutput("lock_valid", 64'(keyValid), 64'h1);

    // Reset asserted while byte 5 is on the bus, then a clean good load.
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    doReset(1'b0, 8'h00);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 8'h11 * 8'(i + 1), 1'b0);
    doReset(1'b1, 8'h66);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    loadBytes(64'h1122334455667788, 8'h88);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("post_reset_key", keyinput, 64'h1122334455667788);
    checkOutput("post_reset_valid", 64'(keyValid), 64'h1);

    // Randomized traffic; checksum is usually made correct so loads complete.
    for (int r = 0; r < 4; r++) begin
      doReset(1'b0, 8'h00);
      for (int c = 0; c < 300; c++) begin
        rs = ($urandom_range(0, 99) < 4);
        rv = ($urandom_range(0, 99) < 70);
        rl = ($urandom_range(0, 99) < 3);
        rb = 8'($urandom_range(0, 255));
        if (mMode == M_LOAD && mBytes.size() == NB && !rs && $urandom_range(0, 99) < 75) begin
          rb = keyXor();
        end
        applyStimulus(rs, rv, rb, rl);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
